key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner_if.sv | 15 +
 rtl/key_conditioner.sv | 98 +++++++++
 tb/tb_key_conditioner.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/key_conditioner_if.sv
// key_conditioner_if: pushbutton/switch inputs, consumer ack and conditioned request outputs.
//   master: drives KEY_n[1:0] (active-low, bit1 accumulate, bit0 clear), SW[7:0], ack
//   slave : drives accum_req, clear_req, sw_snapshot[7:0], key_lvl[1:0], overrun
interface key_conditioner_if;
  logic [1:0] KEY_n;
  logic [7:0] SW;
  logic ack;
  logic accum_req;
  logic clear_req;
  logic [7:0] sw_snapshot;
  logic [1:0] key_lvl;
  logic overrun;
  modport master(output KEY_n, SW, ack, input accum_req, clear_req, sw_snapshot, key_lvl, overrun);
  modport slave(input KEY_n, SW, ack, output accum_req, clear_req, sw_snapshot, key_lvl, overrun);
endinterface

// File: rtl/key_conditioner.sv
// key_conditioner: debounces two active-low keys into sticky accumulate/clear requests with an SW snapshot.
//   Clk, Reset (sync, active-high); bus (key_conditioner_if.slave): KEY_n, SW, ack in;
//   accum_req, clear_req, sw_snapshot, key_lvl, overrun out (all registered).
//   Optional macro KEY_AUTOREPEAT_EN: repeat accumulate events every REPEAT_CYCLES while held.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES = 25000000
) (
  input logic Clk,
  input logic Reset,
  key_conditioner_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;
  localparam logic [19:0] LAST = 20'(DEBOUNCE_CYCLES - 1);
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 1048575 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("key_conditioner: parameter out of range");
  end
  logic [1:0] key_s1, key_s2;
  logic [7:0] sw_s1, sw_s2;
  logic [1:0] ev, lvl_nx;
  logic acc_ev;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_s1 <= 2'b11;
      key_s2 <= 2'b11;
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      key_s1 <= bus.KEY_n;
      key_s2 <= key_s1;
      sw_s1 <= bus.SW;
      sw_s2 <= sw_s1;
    end
  end
  for (genvar k = 0; k < 2; k++) begin : g_key
    state_t st, st_nx;
    logic [19:0] cnt, cnt_nx;
    logic pressed, hit, fire;
    assign pressed = ~key_s2[k];
    assign hit = cnt == LAST;
    always_ff @(posedge Clk) begin
      st <= Reset ? IDLE : st_nx;
      cnt <= Reset ? '0 : cnt_nx;
    end
    always_comb begin
      st_nx = st;
      cnt_nx = cnt;
      fire = 1'b0;
      case (st)
        IDLE: if (pressed) begin
          st_nx = PRESS_CHK;
          cnt_nx = '0;
        end
        PRESS_CHK: if (!pressed) st_nx = IDLE;
          else if (hit) begin
            st_nx = HELD;
            fire = 1'b1;
          end else cnt_nx = cnt + 1'b1;
        HELD: if (!pressed) begin
          st_nx = REL_CHK;
          cnt_nx = '0;
        end
        default: if (pressed) st_nx = HELD;
          else if (hit) st_nx = IDLE;
          else cnt_nx = cnt + 1'b1;
      endcase
    end
    assign ev[k] = fire;
    // key_lvl is registered from the next state so it tracks the state register exactly
    assign lvl_nx[k] = st_nx == HELD || st_nx == REL_CHK;
  end
`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  logic [RW-1:0] rcnt;
  logic rpt;
  assign rpt = g_key[1].st == HELD && rcnt == RW'(REPEAT_CYCLES - 1);
  always_ff @(posedge Clk) rcnt <= (Reset || g_key[1].st != HELD || rpt) ? '0 : rcnt + 1'b1;
  assign acc_ev = ev[1] | rpt;
`else
  assign acc_ev = ev[1];
`endif
  // A new event wins over ack; an event against an unacknowledged pending request is an overrun
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.accum_req <= 1'b0;
      bus.clear_req <= 1'b0;
      bus.sw_snapshot <= '0;
      bus.key_lvl <= '0;
      bus.overrun <= 1'b0;
    end else begin
      if (acc_ev && !(bus.accum_req && !bus.ack)) bus.sw_snapshot <= sw_s2;
      bus.accum_req <= acc_ev | (bus.accum_req & ~bus.ack);
      bus.clear_req <= ev[0] | (bus.clear_req & ~bus.ack);
      bus.key_lvl <= lvl_nx;
      bus.overrun <= bus.overrun | (acc_ev & bus.accum_req & ~bus.ack) | (ev[0] & bus.clear_req & ~bus.ack);
    end
  end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: table-driven and scoreboarded bench for key_conditioner (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16).
module tb_key_conditioner;
  localparam int D = 4;
  localparam int R = 16;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  key_conditioner_if bus();
  key_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (.Clk(clk), .Reset(rst), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  typedef struct {
    logic [7:0] sw;
    int low;
    logic req;
    logic lvl;
  } vec_t;
  vec_t vecs[5];
  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_ack();
    bus.ack = 1'b1;
    tick(1);
    bus.ack = 1'b0;
    tick(1);
  endtask
  task automatic wait_req(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (bus.accum_req) begin
        lat = k;
        break;
      end
    end
  endtask
  task automatic do_reset(string tag);
    rst = 1'b1;
    tick(2);
    check({tag, "_accum_req"}, bus.accum_req, 0);
    check({tag, "_clear_req"}, bus.clear_req, 0);
    check({tag, "_snapshot"}, bus.sw_snapshot, 0);
    check({tag, "_key_lvl"}, bus.key_lvl, 0);
    check({tag, "_overrun"}, bus.overrun, 0);
    rst = 1'b0;
    tick(1);
  endtask
  task automatic press_acc(logic [7:0] sw, int low, logic expect_event);
    bus.SW = sw;
    tick(3);
    if (expect_event) exp_q.push_back(sw);
    bus.KEY_n[1] = 1'b0;
    tick(low);
    bus.KEY_n[1] = 1'b1;
    tick(20);
  endtask
  // Scoreboard: an accepted accumulate shows as accum_req rising or the snapshot changing while requested
  logic prev_req = 1'b0;
  logic [7:0] prev_snap = '0;
  always @(negedge clk) begin
    logic [7:0] e;
    if (bus.accum_req && (!prev_req || bus.sw_snapshot != prev_snap)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: actual snapshot=%0h required no event", bus.sw_snapshot);
      end else begin
        e = exp_q.pop_front();
        check("sb_snapshot", bus.sw_snapshot, e);
      end
    end
    prev_req = bus.accum_req;
    prev_snap = bus.sw_snapshot;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat;
    logic lvl_seen;
    vecs[0] = '{8'hE7, 15, 1'b1, 1'b1};
    vecs[1] = '{8'hA5, 3, 1'b0, 1'b0};
    vecs[2] = '{8'hC3, 4, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 5, 1'b1, 1'b1};
    vecs[4] = '{8'h81, 12, 1'b1, 1'b1};
    bus.KEY_n = 2'b11;
    bus.SW = '0;
    bus.ack = 1'b0;
    tick(1);
    do_reset("reset0");
    bus.SW = 8'h5A;
    tick(3);
    exp_q.push_back(8'h5A);
    bus.KEY_n[1] = 1'b0;
    wait_req(lat);
    check("latency_acc", lat, 7);
    check("lvl_held", bus.key_lvl[1], 1);
    check("snap_5a", bus.sw_snapshot, 8'h5A);
    tick(2);
    pulse_ack();
    if (AR) exp_q.push_back(8'h5A);
    tick(19);
    check("repeat_while_held", bus.accum_req, AR);
    bus.KEY_n[1] = 1'b1;
    tick(20);
    pulse_ack();
    foreach (vecs[i]) begin
      bus.SW = vecs[i].sw;
      tick(3);
      if (vecs[i].req) exp_q.push_back(vecs[i].sw);
      lvl_seen = 1'b0;
      bus.KEY_n[1] = 1'b0;
      for (int c = 0; c < vecs[i].low; c++) begin
        tick(1);
        lvl_seen |= bus.key_lvl[1];
      end
      bus.KEY_n[1] = 1'b1;
      for (int c = 0; c < 20; c++) begin
        tick(1);
        lvl_seen |= bus.key_lvl[1];
      end
      check($sformatf("vec%0d_req", i), bus.accum_req, vecs[i].req);
      check($sformatf("vec%0d_lvl", i), lvl_seen, vecs[i].lvl);
      check($sformatf("vec%0d_lvl_released", i), bus.key_lvl[1], 0);
      check($sformatf("vec%0d_overrun", i), bus.overrun, 0);
      pulse_ack();
      check($sformatf("vec%0d_acked", i), bus.accum_req, 0);
    end
    press_acc(8'h01, 15, 1'b1);
    press_acc(8'h02, 15, 1'b0);
    check("ovr_flag", bus.overrun, 1);
    check("ovr_snapshot", bus.sw_snapshot, 8'h01);
    check("ovr_req", bus.accum_req, 1);
    pulse_ack();
    check("ovr_sticky", bus.overrun, 1);
    do_reset("reset1");
    press_acc(8'h01, 15, 1'b1);
    bus.SW = 8'h33;
    tick(3);
    exp_q.push_back(8'h33);
    bus.KEY_n[1] = 1'b0;
    tick(6);
    bus.ack = 1'b1;
    tick(1);
    bus.ack = 1'b0;
    check("ackcol_req", bus.accum_req, 1);
    check("ackcol_snapshot", bus.sw_snapshot, 8'h33);
    check("ackcol_overrun", bus.overrun, 0);
    tick(8);
    bus.KEY_n[1] = 1'b1;
    tick(20);
    pulse_ack();
    bus.SW = 8'h77;
    tick(3);
    exp_q.push_back(8'h77);
    bus.KEY_n = 2'b00;
    wait_req(lat);
    check("both_latency", lat, 7);
    check("both_clear_same_cycle", bus.clear_req, 1);
    check("both_lvl", bus.key_lvl, 2'b11);
    tick(5);
    bus.KEY_n = 2'b11;
    tick(20);
    pulse_ack();
    check("both_ack_accum", bus.accum_req, 0);
    check("both_ack_clear", bus.clear_req, 0);
    bus.SW = 8'h99;
    tick(3);
    bus.KEY_n[1] = 1'b0;
    tick(4);
    do_reset("reset_mid");
    exp_q.push_back(8'h99);
    wait_req(lat);
    check("rst_requal_latency", lat, 6);
    tick(5);
    bus.KEY_n[1] = 1'b1;
    tick(20);
    check("rst_requal_overrun", bus.overrun, 0);
    pulse_ack();
    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
